// File: rtl/masked_inv_scheduler.sv
// Shares one pipelined masked GF(2^8) inverter between the state-byte (0) and key-schedule (1) requesters.
// Build option: define MASKED_INV_SCHED_KEY_PRIO_EN for fixed key-schedule priority; default is round-robin.

package masked_inv_scheduler_pkg;
    typedef logic [7:0] bv8_t;
endpackage

module masked_inv_scheduler
    import masked_inv_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SHARES  = 2,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned INV_LATENCY = 3
) (
    input  logic                           in_clock,
    input  logic                           in_reset,
    input  logic [1:0]                     in_req_valid,
    output logic [1:0]                     out_req_ready,
    input  bv8_t [1:0][NUM_SHARES-1:0]     in_req_a,
    input  logic [1:0][TAG_WIDTH-1:0]      in_req_tag,
    input  logic                           in_rand_valid,
    output bv8_t [NUM_SHARES-1:0]          out_inv_a,
    input  bv8_t [NUM_SHARES-1:0]          in_inv_b,
    output logic                           out_resp_valid,
    output logic                           out_resp_src,
    output logic [TAG_WIDTH-1:0]           out_resp_tag,
    output bv8_t [NUM_SHARES-1:0]          out_resp_b,
    output logic                           out_busy
);

    typedef struct packed {
        logic                 valid;
        logic                 src;
        logic [TAG_WIDTH-1:0] tag;
    } trk_t;

    trk_t [INV_LATENCY-1:0] trk;
    trk_t                   stage0;
    logic                   grant_any;
    logic                   grant_idx;
    logic                   issue_ok;
    logic                   accept;
    logic                   busy_any;
    logic                   resp_hit;

`ifndef MASKED_INV_SCHED_KEY_PRIO_EN
    logic                   last_grant;
`endif

    // Requester selection; depends only on the valids, never on data or tags
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
`ifdef MASKED_INV_SCHED_KEY_PRIO_EN
        if (in_req_valid[1]) begin
            grant_any = 1'b1;
            grant_idx = 1'b1;
        end else if (in_req_valid[0]) begin
            grant_any = 1'b1;
            grant_idx = 1'b0;
        end
`else
        if (in_req_valid == 2'b11) begin
            grant_any = 1'b1;
            grant_idx = ~last_grant;
        end else if (in_req_valid[0]) begin
            grant_any = 1'b1;
            grant_idx = 1'b0;
        end else if (in_req_valid[1]) begin
            grant_any = 1'b1;
            grant_idx = 1'b1;
        end
`endif
    end

    assign issue_ok = in_rand_valid & ~in_reset;
    assign accept   = grant_any & issue_ok;

    always_comb begin
        out_req_ready = 2'b00;
        if (accept) begin
            out_req_ready[grant_idx] = 1'b1;
        end
    end

    // Share-wise AND-mux: shares are never recombined, and idle cycles feed zero shares
    always_comb begin
        out_inv_a = '0;
        for (int s = 0; s < NUM_SHARES; s++) begin
            out_inv_a[s] = ({8{out_req_ready[0]}} & in_req_a[0][s])
                         | ({8{out_req_ready[1]}} & in_req_a[1][s]);
        end
    end

    always_comb begin
        stage0 = '0;
        if (accept) begin
            stage0.valid = 1'b1;
            stage0.src   = grant_idx;
            stage0.tag   = in_req_tag[grant_idx];
        end
    end

    // Tracker mirrors the inverter pipeline, which never stalls
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            trk <= '0;
        end else begin
            trk[0] <= stage0;
            for (int i = 1; i < INV_LATENCY; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

`ifndef MASKED_INV_SCHED_KEY_PRIO_EN
    // Reset value 1 lets requester 0 win the first contention
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_idx;
        end
    end
`endif

    always_comb begin
        busy_any = 1'b0;
        for (int i = 0; i < INV_LATENCY; i++) begin
            busy_any = busy_any | trk[i].valid;
        end
    end

    // Bytes in flight across a reset are dropped, including the one landing in the reset cycle
    assign resp_hit       = trk[INV_LATENCY-1].valid & ~in_reset;
    assign out_resp_valid = resp_hit;
    assign out_resp_src   = resp_hit & trk[INV_LATENCY-1].src;
    assign out_resp_tag   = resp_hit ? trk[INV_LATENCY-1].tag : '0;
    assign out_busy       = busy_any & ~in_reset;

    always_comb begin
        out_resp_b = '0;
        for (int s = 0; s < NUM_SHARES; s++) begin
            out_resp_b[s] = resp_hit ? in_inv_b[s] : 8'h00;
        end
    end

endmodule

// File: doc/masked_inv_scheduler.md
Name: masked_inv_scheduler

Overview:
- Shares a single pipelined masked GF(2^8) inverter between two requesters: requester 0 is the state-byte path and requester 1 is the key-schedule path.
- Arbitrates between them and issues at most one masked byte per cycle.
- Gates issue on fresh-randomness availability and tracks each byte's tag and source through the fixed inverter latency.
- Returns each inverse with its tag and source index, and sits between the round datapath/key expansion and the inverter instance.

Parameters:
- NUM_SHARES, 2, number of Boolean shares per byte.
- TAG_WIDTH, 4, width of the opaque per-request tag returned with the result.
- INV_LATENCY, 3, inverter input-to-output latency in cycles; must equal the inverter pipeline depth (t0 to t3).

Ports:
- in_clock  input  1  clock.
- in_reset  input  1  reset, synchronous, active-high.
- in_req_valid  input  2  per-requester request valid.
- out_req_ready  output  2  per-requester grant; a request is accepted when valid and ready are both high.
- in_req_a  input  2x NUM_SHARES x 8  masked input byte per requester, typed bv8_t[1:0][NUM_SHARES-1:0].
- in_req_tag  input  2x TAG_WIDTH  tag per requester.
- in_rand_valid  input  1  randomness for this cycle's inverter inputs is fresh.
- out_inv_a  output  NUM_SHARES x 8  shares driven to the inverter input.
- in_inv_b  input  NUM_SHARES x 8  shares from the inverter output.
- out_resp_valid  output  1  result valid.
- out_resp_src  output  1  requester index of the result.
- out_resp_tag  output  TAG_WIDTH  tag of the result.
- out_resp_b  output  NUM_SHARES x 8  masked inverse.
- out_busy  output  1  at least one byte is in flight.

Behaviour:
- Issue conditions:
  - A requester can be granted only when in_rand_valid=1 and in_reset=0.
  - At most one bit of out_req_ready is high per cycle.
  - out_req_ready never depends on in_req_a or in_req_tag.
- Arbitration (default build): round-robin with a 1-bit pointer last_grant.
  - When both requesters are valid, grant !last_grant.
  - When one is valid, grant that one.
  - last_grant updates only on an accepted request.
- Inverter input:
  - out_inv_a = accepted requester's in_req_a in the cycle of acceptance.
  - Otherwise out_inv_a is all-zero shares; stale or unaccepted data must never reach the inverter.
  - out_inv_a is a combinational AND-mux of shares; no share recombination.
- Tracking: shift register of INV_LATENCY entries, each {valid, src, tag}.
  - Stage 0 loads {accept, grant index, tag} every cycle; entries advance every cycle unconditionally.
  - The inverter never stalls.
- Response:
  - out_resp_valid = last tracker entry valid.
  - out_resp_src and out_resp_tag come from that entry.
  - out_resp_b = in_inv_b when valid, else all zeros.
  - A byte accepted at cycle n responds at cycle n+INV_LATENCY.
- Response path: no backpressure; consumers must accept every response.
- Throughput: back-to-back acceptance every cycle while in_rand_valid stays high; responses keep acceptance order.
- Randomness drop: if in_rand_valid=0, both readies are 0 and a bubble (valid=0, zero shares) enters the pipeline.
- out_busy = OR of all tracker valid bits.
- Reset (synchronous):
  - All tracker entries are cleared and last_grant=1, so requester 0 wins the first contention.
  - out_resp_valid=0, out_resp_src=0, out_resp_tag=0, out_resp_b=0, out_busy=0, out_req_ready=0.
- Reset mid-operation: in-flight bytes are dropped and no response is emitted for them, including bytes whose inverter output appears after reset deasserts.
- Simultaneous accept and response in the same cycle is normal operation and is independent.

Optional Feature:
- Macro: MASKED_INV_SCHED_KEY_PRIO_EN.
- Defined: fixed priority. Requester 1 (key schedule) wins whenever valid; requester 0 is granted only when requester 1 is idle, and last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Single request (NUM_SHARES=2): req0 byte 0x53 as shares (0xA5,0xF6), tag 0x3, rand valid at cycle 10. Requires out_req_ready[0]=1 at cycle 10; out_resp_valid=1 at cycle 13 with src=0, tag=0x3, and XOR of out_resp_b shares = 0xCA. out_busy high during cycles 11-13.
- Contention round-robin: both requesters valid continuously for 4 cycles after reset. Grants must be 0,1,0,1; responses appear 3 cycles later in the same order with matching tags. With MASKED_INV_SCHED_KEY_PRIO_EN, grants must be 1,1,1,1.
- Randomness gating: both requesters valid while in_rand_valid toggles 1,0,1. Requires no grant and out_inv_a=0 in the low cycle, and a response bubble (out_resp_valid=0) exactly 3 cycles later.
- Identity values: inputs 0x00 and 0x01 on back-to-back cycles. Recombined responses must be 0x00 then 0x01 on consecutive cycles.
- Reset mid-flight: accept 2 bytes, then assert in_reset for 1 cycle before either responds. Requires no out_resp_valid afterwards, out_busy=0 and out_resp_b=0 on the cycle after reset, and a new request completing normally with latency 3.
